branch_resolve_unit: RTL



---
 rtl/branch_resolve_unit_pkg.sv | 23 ++
 rtl/branch_resolve_unit_ras_stack.sv | 51 +++++
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: opcodes, flag bit positions
// and the flush FSM encoding.
package branch_pkg;

  localparam logic [5:0] OP_B    = 6'b001000;
  localparam logic [5:0] OP_BL   = 6'b001001;
  localparam logic [5:0] OP_BLTZ = 6'b001010;
  localparam logic [5:0] OP_BZ   = 6'b001011;
  localparam logic [5:0] OP_BNZ  = 6'b001100;
  localparam logic [5:0] OP_RET  = 6'b001101;
  localparam logic [5:0] OP_BCY  = 6'b001110;
  localparam logic [5:0] OP_BNCY = 6'b001111;

  localparam int FLG_S = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// the count saturates at RAS_DEPTH while the pointer keeps wrapping.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [CW-1:0]     count_o
);

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] mem_q;
  logic [PW-1:0]                    ptr_q, ptr_d, ptr_m1;
  logic [CW-1:0]                    count_q, count_d;

  // ptr_q is the next free slot, so the top lives one below it
  assign ptr_m1  = ptr_q - PW'(1);
  assign top_o   = mem_q[ptr_m1];
  assign count_o = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (count_q != CW'(RAS_DEPTH)) count_d = count_q + CW'(1);
    end else if (pop_i && count_q != '0) begin
      ptr_d   = ptr_m1;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[ptr_q] <= push_data_i;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: architectural flags, condition check,
// registered redirect/link pulses, bounded flush window and return-address stack.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter int FLUSH_LEN = 2,
  parameter int PC_INC    = 4,
  localparam int CW = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] target_in,
  input  logic              flag_we,
  input  logic              sign_in,
  input  logic              zero_in,
  input  logic              carry_in,
  output logic              ready,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [2:0]        flags_q,
  output logic [CW-1:0]     ras_count,
  output logic              ras_err
);

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  // RET is reported as met here; the top gates it with RAS occupancy
  function automatic logic cond_met(input logic [5:0] op, input logic [2:0] f);
    case (op)
      OP_B, OP_BL, OP_RET: cond_met = 1'b1;
      OP_BLTZ:             cond_met = f[FLG_S] & ~f[FLG_Z];
      OP_BZ:               cond_met = f[FLG_Z];
      OP_BNZ:              cond_met = ~f[FLG_Z];
      OP_BCY:              cond_met = f[FLG_C];
      OP_BNCY:             cond_met = ~f[FLG_C];
      default:             cond_met = 1'b0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [FW-1:0]     cnt_q, cnt_d;
  logic [2:0]        flags_in, eff;
  logic              accept, is_ret, ras_empty, taken, push, pop, err_d;
  logic [ADDR_W-1:0] ras_top, tgt, link_addr;
  logic              redirect_q, link_we_q, ras_err_q;
  logic [ADDR_W-1:0] redirect_pc_q, link_data_q;

  assign flags_in  = {sign_in, zero_in, carry_in};
  assign eff       = flag_we ? flags_in : flags_q;
  assign accept    = valid_in & ready;
  assign is_ret    = (opcode == OP_RET);
  assign ras_empty = (ras_count == '0);
  assign taken     = accept & cond_met(opcode, eff) & ~(is_ret & ras_empty);
  assign push      = accept & (opcode == OP_BL);
  assign pop       = taken & is_ret;
  assign err_d     = accept & is_ret & ras_empty;
  assign tgt       = is_ret ? ras_top : target_in;
  assign link_addr = pc_in + ADDR_W'(PC_INC);

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(link_addr),
    .top_o      (ras_top),
    .count_o    (ras_count)
  );

  // Flush window starts with the redirect cycle and lasts FLUSH_LEN cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (taken) begin
        state_d = FLUSH;
        cnt_d   = FW'(FLUSH_LEN - 1);
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - FW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flags_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_we_q     <= 1'b0;
      link_data_q   <= '0;
      ras_err_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= taken;
      link_we_q  <= push;
      ras_err_q  <= err_d;
      if (flag_we) flags_q       <= flags_in;
      if (taken)   redirect_pc_q <= tgt;
      if (push)    link_data_q   <= link_addr;
    end
  end

  assign ready       = (state_q == IDLE);
  assign flush       = (state_q == FLUSH);
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign link_we     = link_we_q;
  assign link_data   = link_data_q;
  assign ras_err     = ras_err_q;

endmodule
